// File: rtl/logic_op_server.sv
// Slice-serial 8-op bitwise server: rsp_valid rises NSLICE+1 cycles after acceptance; result held until rsp_ready.
// Single-outstanding (req_ready only in IDLE); `LOGIC_OP_FLAGS_EN adds rsp_zero/rsp_parity outputs.
module logic_op_server #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
`ifdef LOGIC_OP_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_parity
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_slice_chk
    $error("logic_op_server: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [CW-1:0]    cnt_q;
  logic             req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [SLICE-1:0] sl_a, sl_b, sl_r;
  logic             last_slice;
  int               idx;

`ifdef LOGIC_OP_FLAGS_EN
  logic zacc_q, zacc_d, pacc_q, pacc_d, zero_q, parity_q;
`endif

  always_comb begin
    idx        = int'(cnt_q) * SLICE;
    sl_a       = a_q[idx +: SLICE];
    sl_b       = b_q[idx +: SLICE];
    last_slice = (cnt_q == CW'(NSLICE - 1));
    case (op_q)
      3'd0:    sl_r = sl_a & sl_b;
      3'd1:    sl_r = sl_a | sl_b;
      3'd2:    sl_r = sl_a ^ sl_b;
      3'd3:    sl_r = ~sl_a;
      3'd4:    sl_r = ~(sl_a | sl_b);
      3'd5:    sl_r = ~(sl_a & sl_b);
      3'd6:    sl_r = ~(sl_a ^ sl_b);
      default: sl_r = '0;
    endcase
    res_d             = res_q;
    res_d[idx +: SLICE] = sl_r;
`ifdef LOGIC_OP_FLAGS_EN
    zacc_d = zacc_q & ~(|sl_r);
    pacc_d = pacc_q ^ (^sl_r);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LOGIC_OP_FLAGS_EN
      zacc_q      <= 1'b0;
      pacc_q      <= 1'b0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            res_q       <= '0;
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_BUSY;
`ifdef LOGIC_OP_FLAGS_EN
            zacc_q      <= 1'b1;
            pacc_q      <= 1'b0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
`endif
          end
        end
        S_BUSY: begin
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
`ifdef LOGIC_OP_FLAGS_EN
          zacc_q <= zacc_d;
          pacc_q <= pacc_d;
`endif
          if (last_slice) begin
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= (op_q == 3'd7);
            state_q     <= S_DONE;
`ifdef LOGIC_OP_FLAGS_EN
            // An illegal opcode reports no flags even though its result is zero.
            zero_q      <= (op_q != 3'd7) & zacc_d;
            parity_q    <= pacc_d;
`endif
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
`ifdef LOGIC_OP_FLAGS_EN
  assign rsp_zero   = zero_q;
  assign rsp_parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_server.sv
// Directed bench for logic_op_server: main instance (SLICE=2) plus SLICE=1/4/8 instances for the latency/model sweep.
module tb_logic_op_server;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b, rsp_result;

  logic       sw_valid;
  logic [2:0] sw_op;
  logic [7:0] sw_a, sw_b;
  logic       s1_rdy, s1_vld, s1_err, s1_busy;
  logic       s4_rdy, s4_vld, s4_err, s4_busy;
  logic       s8_rdy, s8_vld, s8_err, s8_busy;
  logic [7:0] s1_res, s4_res, s8_res;

`ifdef LOGIC_OP_FLAGS_EN
  logic rsp_zero, rsp_parity, s1_z, s1_p, s4_z, s4_p, s8_z, s8_p;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  logic_op_server #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
`ifdef LOGIC_OP_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_parity(rsp_parity)
`endif
  );

  logic_op_server #(.WIDTH(8), .SLICE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(sw_valid), .req_ready(s1_rdy),
    .req_op(sw_op), .req_a(sw_a), .req_b(sw_b), .rsp_valid(s1_vld),
    .rsp_ready(1'b1), .rsp_result(s1_res), .rsp_err(s1_err), .busy(s1_busy)
`ifdef LOGIC_OP_FLAGS_EN
    , .rsp_zero(s1_z), .rsp_parity(s1_p)
`endif
  );

  logic_op_server #(.WIDTH(8), .SLICE(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .req_valid(sw_valid), .req_ready(s4_rdy),
    .req_op(sw_op), .req_a(sw_a), .req_b(sw_b), .rsp_valid(s4_vld),
    .rsp_ready(1'b1), .rsp_result(s4_res), .rsp_err(s4_err), .busy(s4_busy)
`ifdef LOGIC_OP_FLAGS_EN
    , .rsp_zero(s4_z), .rsp_parity(s4_p)
`endif
  );

  logic_op_server #(.WIDTH(8), .SLICE(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .req_valid(sw_valid), .req_ready(s8_rdy),
    .req_op(sw_op), .req_a(sw_a), .req_b(sw_b), .rsp_valid(s8_vld),
    .rsp_ready(1'b1), .rsp_result(s8_res), .rsp_err(s8_err), .busy(s8_busy)
`ifdef LOGIC_OP_FLAGS_EN
    , .rsp_zero(s8_z), .rsp_parity(s8_p)
`endif
  );

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a | b);
      3'd5:    return ~(a & b);
      3'd6:    return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns #1 after the edge that accepted it.
  task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Latency counts the acceptance edge as 1; 0 means rsp_valid never came.
  task automatic wait_rsp(output int lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
    lat = rsp_valid ? n : 0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
    int lat;
    do_req(op, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_res"}, 32'(rsp_result), 32'(exp));
    check({tag, "_err"}, 32'(rsp_err), 32'(op == 3'd7));
    @(posedge clk); #1;
  endtask

  task automatic sweep_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n, l1, l4, l8;
    logic [7:0] r1, r4, r8;
    logic e1, e4, e8;
    logic [7:0] exp;
    n = 0;
    while (!(s1_rdy && s4_rdy && s8_rdy) && n < 50) begin @(posedge clk); #1; n++; end
    sw_valid = 1'b1; sw_op = op; sw_a = a; sw_b = b;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    l1 = 0; l4 = 0; l8 = 0;
    r1 = 'x; r4 = 'x; r8 = 'x; e1 = 1'bx; e4 = 1'bx; e8 = 1'bx;
    n = 1;
    while (n <= 20) begin
      if (s1_vld && l1 == 0) begin l1 = n; r1 = s1_res; e1 = s1_err; end
      if (s4_vld && l4 == 0) begin l4 = n; r4 = s4_res; e4 = s4_err; end
      if (s8_vld && l8 == 0) begin l8 = n; r8 = s8_res; e8 = s8_err; end
      if (l1 != 0 && l4 != 0 && l8 != 0) break;
      @(posedge clk); #1;
      n++;
    end
    exp = ref_op(op, a, b);
    check("sw_s1_lat", 32'(l1), 32'd9);
    check("sw_s4_lat", 32'(l4), 32'd3);
    check("sw_s8_lat", 32'(l8), 32'd2);
    check("sw_s1_res", 32'(r1), 32'(exp));
    check("sw_s4_res", 32'(r4), 32'(exp));
    check("sw_s8_res", 32'(r8), 32'(exp));
    check("sw_err", 32'({e1, e4, e8}), (op == 3'd7) ? 32'd7 : 32'd0);
  endtask

  initial begin
    int lat, vcnt;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    sw_valid = 1'b0; sw_op = '0; sw_a = '0; sw_b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while BUSY discards the request.
    do_req(3'd0, 8'h0F, 8'hAA);
    repeat (2) @(posedge clk);
    #1;
    check("midbusy_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_result", 32'(rsp_result), 32'd0);
    #2;
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) vcnt++;
    end
    check("midrst_no_rsp", 32'(vcnt), 32'd0);

    run_op("and",  3'd0, 8'h0F, 8'hAA, 8'h0A);
    run_op("or",   3'd1, 8'h0F, 8'hAA, 8'hAF);
    run_op("xor",  3'd2, 8'h0F, 8'hAA, 8'hA5);
    run_op("not",  3'd3, 8'h0F, 8'h5C, 8'hF0);
    run_op("nor",  3'd4, 8'h00, 8'hFF, 8'h00);
    run_op("nand", 3'd5, 8'hFF, 8'h00, 8'hFF);
    run_op("xnor", 3'd6, 8'hAA, 8'h55, 8'h00);
    run_op("and2", 3'd0, 8'h3C, 8'hF5, 8'h34);

    // Backpressure: result held, second request blocked.
    rsp_ready = 1'b0;
    do_req(3'd2, 8'hF0, 8'hAA);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd5);
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h33; req_b = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", 32'(rsp_result), 32'h5A);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_still_held", 32'(rsp_result), 32'h5A);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drop_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_busy", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("bp_second_lat", 32'(lat), 32'd5);
    check("bp_second_res", 32'(rsp_result), 32'h03);
    @(posedge clk); #1;

    run_op("illegal", 3'd7, 8'hFF, 8'hFF, 8'h00);
    run_op("legal_after", 3'd1, 8'h01, 8'h02, 8'h03);

`ifdef LOGIC_OP_FLAGS_EN
    do_req(3'd0, 8'hF0, 8'h0F);
    wait_rsp(lat);
    check("flg_and_zero", 32'(rsp_zero), 32'd1);
    check("flg_and_par", 32'(rsp_parity), 32'd0);
    @(posedge clk); #1;
    do_req(3'd1, 8'h01, 8'h02);
    wait_rsp(lat);
    check("flg_or_zero", 32'(rsp_zero), 32'd0);
    check("flg_or_par", 32'(rsp_parity), 32'd0);
    @(posedge clk); #1;
    do_req(3'd2, 8'h07, 8'h00);
    wait_rsp(lat);
    check("flg_xor_zero", 32'(rsp_zero), 32'd0);
    check("flg_xor_par", 32'(rsp_parity), 32'd1);
    @(posedge clk); #1;
    do_req(3'd7, 8'h00, 8'h00);
    wait_rsp(lat);
    check("flg_ill_zero", 32'(rsp_zero), 32'd0);
    check("flg_ill_par", 32'(rsp_parity), 32'd0);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      sweep_txn(op, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
